// File: rtl/key_voice_alloc.sv
// Keyboard-to-synth voice allocator: scans each HID report once for released
// voices, then once per slot for new notes, octave shifts and instrument picks.
module key_voice_alloc #(
  parameter int NKEYS   = 6,
  parameter int NVOICES = 4,
  parameter int INSTR_W = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   report_valid,
  input  logic [8*NKEYS-1:0]     report_keys,
  output logic                   busy,
  output logic                   update,
  output logic [NVOICES-1:0]     voice_gate,
  output logic [4*NVOICES-1:0]   voice_note,
  output logic [3*NVOICES-1:0]   voice_octave,
  output logic [INSTR_W-1:0]     instrument,
  output logic [1:0]             dbg_state
);

  // Handshake: report_valid is a one-cycle strobe honoured only while busy is low;
  // update pulses once when the outputs reflect the accepted report.
  typedef enum logic [1:0] {IDLE, REL_SCAN, PRS_SCAN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [8*NKEYS-1:0]     keys_q, keys_d;
  logic                   en_q, en_d;
  logic                   update_q, update_d;
  logic [NVOICES-1:0]     gate_q, gate_d;
  logic [7:0]             key_q  [NVOICES];
  logic [7:0]             key_d  [NVOICES];
  logic [3:0]             note_q [NVOICES];
  logic [3:0]             note_d [NVOICES];
  logic [2:0]             oct_q  [NVOICES];
  logic [2:0]             oct_d  [NVOICES];
  logic [2:0]             base_q, base_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;

  logic [7:0] slot;
  logic [6:0] map;
  logic [7:0] ioff;
  logic       hit, owned, found;

  // Returns {valid, octave offset from base, semitone}.
  function automatic logic [6:0] note_map(input logic [7:0] k);
    case (k)
      8'h1D: note_map = {1'b1, 2'd0, 4'd0};
      8'h16: note_map = {1'b1, 2'd0, 4'd1};
      8'h1B: note_map = {1'b1, 2'd0, 4'd2};
      8'h07: note_map = {1'b1, 2'd0, 4'd3};
      8'h06: note_map = {1'b1, 2'd0, 4'd4};
      8'h19: note_map = {1'b1, 2'd0, 4'd5};
      8'h0A: note_map = {1'b1, 2'd0, 4'd6};
      8'h05: note_map = {1'b1, 2'd0, 4'd7};
      8'h0B: note_map = {1'b1, 2'd0, 4'd8};
      8'h11: note_map = {1'b1, 2'd0, 4'd9};
      8'h0D: note_map = {1'b1, 2'd0, 4'd10};
      8'h10: note_map = {1'b1, 2'd0, 4'd11};
      8'h14: note_map = {1'b1, 2'd1, 4'd0};
      8'h1F: note_map = {1'b1, 2'd1, 4'd1};
      8'h1A: note_map = {1'b1, 2'd1, 4'd2};
      8'h20: note_map = {1'b1, 2'd1, 4'd3};
      8'h08: note_map = {1'b1, 2'd1, 4'd4};
      8'h15: note_map = {1'b1, 2'd1, 4'd5};
      8'h22: note_map = {1'b1, 2'd1, 4'd6};
      8'h17: note_map = {1'b1, 2'd1, 4'd7};
      8'h23: note_map = {1'b1, 2'd1, 4'd8};
      8'h1C: note_map = {1'b1, 2'd1, 4'd9};
      8'h24: note_map = {1'b1, 2'd1, 4'd10};
      8'h18: note_map = {1'b1, 2'd1, 4'd11};
      8'h0C: note_map = {1'b1, 2'd2, 4'd0};
      default: note_map = 7'd0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    keys_d   = keys_q;
    en_d     = 1'b1;
    update_d = 1'b0;
    gate_d   = gate_q;
    key_d    = key_q;
    note_d   = note_q;
    oct_d    = oct_q;
    base_d   = base_q;
    instr_d  = instr_q;
    hit      = 1'b0;
    owned    = 1'b0;
    found    = 1'b0;
    slot     = 8'h00;
    for (int k = 0; k < NKEYS; k++)
      if (idx_q == 4'(k)) slot = keys_q[8*k +: 8];
    map  = note_map(slot);
    ioff = slot - 8'h3A;

    case (state_q)
      IDLE: begin
        // Slot 0 = 0x01 is the keyboard's rollover error report: drop it whole.
        if (report_valid && en_q && report_keys[7:0] != 8'h01) begin
          keys_d  = report_keys;
          idx_d   = 4'd0;
          state_d = REL_SCAN;
        end
      end
      REL_SCAN: begin
        for (int v = 0; v < NVOICES; v++) begin
          if (idx_q == 4'(v) && gate_q[v]) begin
            hit = 1'b0;
            for (int k = 0; k < NKEYS; k++)
              if (keys_q[8*k +: 8] == key_q[v]) hit = 1'b1;
            if (!hit) gate_d[v] = 1'b0;
          end
        end
        if (idx_q == 4'(NVOICES - 1)) begin
          idx_d   = 4'd0;
          state_d = PRS_SCAN;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      PRS_SCAN: begin
        for (int v = 0; v < NVOICES; v++)
          if (gate_q[v] && key_q[v] == slot) owned = 1'b1;
        if (map[6] && !owned) begin
          for (int v = 0; v < NVOICES; v++) begin
            if (!found && !gate_q[v]) begin
              found     = 1'b1;
              gate_d[v] = 1'b1;
              key_d[v]  = slot;
              note_d[v] = map[3:0];
              oct_d[v]  = base_q + 3'(map[5:4]);
            end
          end
        end
        if (slot == 8'h2D && base_q != 3'd0) base_d = base_q - 3'd1;
        if (slot == 8'h2E && base_q != 3'd5) base_d = base_q + 3'd1;
        if (slot >= 8'h3A && 32'(ioff) < (32'd1 << INSTR_W))
          instr_d = ioff[INSTR_W-1:0];
        if (idx_q == 4'(NKEYS - 1)) begin
          state_d  = DONE;
          update_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      keys_q   <= '0;
      en_q     <= 1'b0;
      update_q <= 1'b0;
      gate_q   <= '0;
      base_q   <= 3'd3;
      instr_q  <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        key_q[v]  <= 8'h00;
        note_q[v] <= 4'd0;
        oct_q[v]  <= 3'd0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      keys_q   <= keys_d;
      en_q     <= en_d;
      update_q <= update_d;
      gate_q   <= gate_d;
      base_q   <= base_d;
      instr_q  <= instr_d;
      key_q    <= key_d;
      note_q   <= note_d;
      oct_q    <= oct_d;
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    update       = update_q;
    voice_gate   = gate_q;
    instrument   = instr_q;
    dbg_state    = state_q;
    voice_note   = '0;
    voice_octave = '0;
    for (int v = 0; v < NVOICES; v++) begin
      voice_note[4*v +: 4]   = note_q[v];
      voice_octave[3*v +: 3] = oct_q[v];
    end
  end

endmodule

// File: tb/tb_key_voice_alloc.sv
// Directed bench for key_voice_alloc at default parameters (6 slots, 4 voices).
module tb_key_voice_alloc;
  localparam int NK = 6;
  localparam int NV = 4;
  localparam int IW = 2;
  localparam int LAT = NV + NK + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            report_valid = 1'b0;
  logic [8*NK-1:0] report_keys = '0;
  logic            busy, update;
  logic [NV-1:0]   voice_gate;
  logic [4*NV-1:0] voice_note;
  logic [3*NV-1:0] voice_octave;
  logic [IW-1:0]   instrument;
  logic [1:0]      dbg_state;

  key_voice_alloc #(.NKEYS(NK), .NVOICES(NV), .INSTR_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .report_valid(report_valid),
    .report_keys(report_keys), .busy(busy), .update(update),
    .voice_gate(voice_gate), .voice_note(voice_note),
    .voice_octave(voice_octave), .instrument(instrument), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {gate, note, octave, instrument}
  logic [33:0] exp_q[$];

  typedef struct {
    logic [47:0] keys;
    logic [3:0]  gate;
    logic [15:0] note;
    logic [11:0] oct;
    logic [1:0]  instr;
  } vec_t;
  vec_t vecs[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] rk(input logic [7:0] k0, input logic [7:0] k1,
                                     input logic [7:0] k2, input logic [7:0] k3,
                                     input logic [7:0] k4, input logic [7:0] k5);
    rk = {k5, k4, k3, k2, k1, k0};
  endfunction

  function automatic logic [11:0] oc(input int a3, input int a2, input int a1, input int a0);
    oc = {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Sends one report, optionally pokes a second strobe while busy, and checks
  // latency, outputs against the scoreboard head and busy release.
  task automatic run_report(input logic [47:0] k, input string tag,
                            input int poke, input logic [47:0] pk);
    int lat;
    logic [33:0] e;
    cycle();
    report_valid = 1'b1;
    report_keys  = k;
    cycle();
    report_valid = 1'b0;
    lat = 1;
    check({tag, " busy"}, 64'(busy), 64'd1);
    while (update !== 1'b1 && lat < 40) begin
      if (lat == poke) begin
        report_valid = 1'b1;
        report_keys  = pk;
      end
      cycle();
      report_valid = 1'b0;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    e = exp_q.pop_front();
    check({tag, " gate"},  64'(voice_gate),   64'(e[33:30]));
    check({tag, " note"},  64'(voice_note),   64'(e[29:14]));
    check({tag, " oct"},   64'(voice_octave), 64'(e[13:2]));
    check({tag, " instr"}, 64'(instrument),   64'(e[1:0]));
    cycle();
    check({tag, " busy_after"}, 64'({busy, update}), 64'd0);
  endtask

  task automatic quiet_window(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (busy || update) seen++;
    end
    check({tag, " quiet"}, 64'(seen), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{rk(8'h1D,0,0,0,0,0),             4'b0001, 16'h0000, oc(0,0,0,3), 2'd0};
    vecs[1]  = '{rk(8'h1D,8'h07,8'h0C,0,0,0),     4'b0111, 16'h0030, oc(0,5,3,3), 2'd0};
    vecs[2]  = '{rk(0,0,0,0,0,0),                 4'b0000, 16'h0030, oc(0,5,3,3), 2'd0};
    vecs[3]  = '{rk(8'h1D,8'h16,8'h1B,8'h07,8'h06,0), 4'b1111, 16'h3210, oc(3,3,3,3), 2'd0};
    vecs[4]  = '{rk(0,0,0,0,0,0),                 4'b0000, 16'h3210, oc(3,3,3,3), 2'd0};
    vecs[5]  = '{rk(8'h2E,8'h14,0,0,0,0),         4'b0001, 16'h3210, oc(3,3,3,5), 2'd0};
    vecs[6]  = '{rk(8'h2E,0,0,0,0,0),             4'b0000, 16'h3210, oc(3,3,3,5), 2'd0};
    vecs[7]  = '{rk(8'h2E,0,0,0,0,0),             4'b0000, 16'h3210, oc(3,3,3,5), 2'd0};
    vecs[8]  = '{rk(8'h2E,0,0,0,0,0),             4'b0000, 16'h3210, oc(3,3,3,5), 2'd0};
    vecs[9]  = '{rk(8'h1D,0,0,0,0,0),             4'b0001, 16'h3210, oc(3,3,3,5), 2'd0};
    vecs[10] = '{rk(8'h2D,8'h2D,8'h2D,8'h2D,8'h2D,8'h2D), 4'b0000, 16'h3210, oc(3,3,3,5), 2'd0};
    vecs[11] = '{rk(8'h2D,8'h1D,0,0,0,0),         4'b0001, 16'h3210, oc(3,3,3,0), 2'd0};
    vecs[12] = '{rk(8'h3B,0,0,0,0,0),             4'b0000, 16'h3210, oc(3,3,3,0), 2'd1};
    vecs[13] = '{rk(8'h3B,8'h3A,0,0,0,0),         4'b0000, 16'h3210, oc(3,3,3,0), 2'd0};
    vecs[14] = '{rk(8'h3D,8'h3C,0,0,0,0),         4'b0000, 16'h3210, oc(3,3,3,0), 2'd2};
    vecs[15] = '{rk(0,0,0,0,0,0),                 4'b0000, 16'h3210, oc(3,3,3,0), 2'd2};
    vecs[16] = '{rk(8'h3E,0,0,0,0,0),             4'b0000, 16'h3210, oc(3,3,3,0), 2'd2};
    vecs[17] = '{rk(8'h1D,8'h1D,0,0,0,0),         4'b0001, 16'h3210, oc(3,3,3,0), 2'd2};
    vecs[18] = '{rk(8'h1D,8'h16,0,0,0,0),         4'b0011, 16'h3210, oc(3,3,0,0), 2'd2};
    vecs[19] = '{rk(8'h16,8'h07,0,0,0,0),         4'b0011, 16'h3213, oc(3,3,0,0), 2'd2};
    vecs[20] = '{rk(8'h04,8'h0C,0,0,0,0),         4'b0001, 16'h3210, oc(3,3,0,2), 2'd2};

    // reset state, with a strobe held through reset and the first cycle after
    report_valid = 1'b1;
    report_keys  = rk(8'h1D,0,0,0,0,0);
    repeat (3) cycle();
    check("reset outputs", {busy, update, voice_gate, voice_note, voice_octave, instrument},
          '0);
    reset_n = 1'b1;
    cycle();
    report_valid = 1'b0;
    check("post-release strobe ignored", 64'(busy), 64'd0);
    repeat (2) cycle();

    for (int i = 0; i < 21; i++) begin
      exp_q.push_back({vecs[i].gate, vecs[i].note, vecs[i].oct, vecs[i].instr});
      run_report(vecs[i].keys, $sformatf("v%0d", i), 0, '0);
    end

    // second strobe while busy must be dropped
    exp_q.push_back({4'b0001, 16'h3210, oc(3,3,0,0), 2'd2});
    run_report(rk(8'h1D,0,0,0,0,0), "busy_poke", 3, rk(8'h0C,0,0,0,0,0));
    quiet_window("busy_poke", 5);

    // rollover report: nothing happens
    cycle();
    report_valid = 1'b1;
    report_keys  = rk(8'h01,8'h0C,0,0,0,0);
    cycle();
    report_valid = 1'b0;
    check("rollover busy", 64'(busy), 64'd0);
    quiet_window("rollover", 20);
    check("rollover hold", {voice_gate, voice_note, voice_octave, instrument},
          {4'b0001, 16'h3210, oc(3,3,0,0), 2'd2});

    // asynchronous reset in the middle of the release scan
    cycle();
    report_valid = 1'b1;
    report_keys  = rk(8'h0C,0,0,0,0,0);
    cycle();
    report_valid = 1'b0;
    cycle();
    check("midscan state", 64'(dbg_state), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midscan reset outputs",
          {busy, update, voice_gate, voice_note, voice_octave, instrument}, '0);
    cycle();
    reset_n = 1'b1;
    quiet_window("midscan", 20);

    // octave base must be back at 3
    exp_q.push_back({4'b0001, 16'h0000, oc(0,0,0,3), 2'd0});
    run_report(rk(8'h1D,0,0,0,0,0), "after_reset", 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
